// File: rtl/bus_bridge_target_if.sv
// Target-side end of the bus bridge: captures a bus transaction, forwards it to the
// bridge core and returns the response. Optional split support: BUS_BRIDGE_TARGET_SPLIT_EN.
package bus_bridge_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  write_data;
    logic        is_write;
  } bus_bridge_req_t;

  typedef struct packed {
    logic       is_write;
    logic [7:0] read_data;
  } bus_bridge_resp_t;

endpackage

module bus_bridge_target_if
  import bus_bridge_pkg::*;
#(
  parameter int unsigned SPLIT_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             req_valid,
  input  logic             req_ready,
  output bus_bridge_req_t  req_payload,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  bus_bridge_resp_t resp_payload,
  input  logic             s_select,
  input  logic [15:0]      s_address_in,
  input  logic             s_address_in_valid,
  input  logic [7:0]       s_data_in,
  input  logic             s_data_in_valid,
  input  logic             s_rw,
  output logic             s_ready,
  output logic [7:0]       s_data_out,
  output logic             s_data_out_valid,
  output logic             s_ack,
  output logic             s_split_ack,
  output logic             s_split_req,
  input  logic             s_split_grant
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  // T_ACK is the cycle in which s_ack is visible; the bus is released after it.
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
  typedef enum logic [2:0] {
    T_IDLE, T_REQ, T_WAIT_RESP, T_RESP, T_ACK, T_SPLIT_WAIT, T_SPLIT_REQ
  } state_t;
`else
  typedef enum logic [2:0] {
    T_IDLE, T_REQ, T_WAIT_RESP, T_RESP, T_ACK
  } state_t;
`endif

  state_t              state_q, state_n;
  bus_bridge_req_t     req_q, req_n;
  logic                req_valid_q, req_valid_n;
  logic                resp_ready_q, resp_ready_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic [DATA_W-1:0]   s_data_out_q, s_data_out_n;
  logic                s_data_out_valid_q, s_data_out_valid_n;
  logic                s_ack_q, s_ack_n;
  logic                s_ready_q, s_ready_n;
  logic                addr_cap_q, addr_cap_n;
  logic                data_cap_q, data_cap_n;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                split_ack_q, split_ack_n;
  logic                split_req_q, split_req_n;
`endif

  // Response direction is not checked; split inputs are idle in the default build.
  logic unused_c;
  assign unused_c = ^{resp_payload.is_write, s_split_grant, CNT_W'(SPLIT_TIMEOUT)};

  // Next-state and next-output logic
  always_comb begin
    state_n            = state_q;
    req_n              = req_q;
    req_valid_n        = req_valid_q;
    resp_ready_n       = resp_ready_q;
    rdata_n            = rdata_q;
    s_data_out_n       = s_data_out_q;
    s_data_out_valid_n = 1'b0;
    s_ack_n            = 1'b0;
    addr_cap_n         = addr_cap_q;
    data_cap_n         = data_cap_q;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
    cnt_n              = cnt_q;
    split_ack_n        = 1'b0;
    split_req_n        = split_req_q;
`endif

    case (state_q)
      T_IDLE: begin
        if (addr_cap_q && (data_cap_q || !req_q.is_write)) begin
          state_n     = T_REQ;
          req_valid_n = 1'b1;
        end else begin
          if (s_select && s_address_in_valid) begin
            req_n.addr     = s_address_in;
            req_n.is_write = s_rw;
            addr_cap_n     = 1'b1;
          end
          if (s_select && s_data_in_valid) begin
            req_n.write_data = s_data_in;
            data_cap_n       = 1'b1;
          end
        end
      end
      T_REQ: begin
        if (req_valid_q && req_ready) begin
          req_valid_n  = 1'b0;
          resp_ready_n = 1'b1;
          state_n      = T_WAIT_RESP;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
          cnt_n        = '0;
`endif
        end
      end
      T_WAIT_RESP: begin
        if (resp_valid) begin
          rdata_n      = resp_payload.read_data;
          resp_ready_n = 1'b0;
          state_n      = T_RESP;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
        end else if (cnt_q == CNT_W'(SPLIT_TIMEOUT - 1)) begin
          split_ack_n = 1'b1;
          state_n     = T_SPLIT_WAIT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
`endif
        end
      end
      T_RESP: begin
        if (!req_q.is_write) begin
          s_data_out_n       = rdata_q;
          s_data_out_valid_n = 1'b1;
        end
        s_ack_n = 1'b1;
        state_n = T_ACK;
      end
      T_ACK: begin
        addr_cap_n = 1'b0;
        data_cap_n = 1'b0;
        state_n    = T_IDLE;
      end
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
      T_SPLIT_WAIT: begin
        resp_ready_n = 1'b1;
        if (resp_valid) begin
          rdata_n      = resp_payload.read_data;
          resp_ready_n = 1'b0;
          split_req_n  = 1'b1;
          state_n      = T_SPLIT_REQ;
        end
      end
      T_SPLIT_REQ: begin
        if (s_split_grant) begin
          split_req_n = 1'b0;
          state_n     = T_RESP;
        end
      end
`endif
      default: begin
        state_n      = T_IDLE;
        req_valid_n  = 1'b0;
        resp_ready_n = 1'b0;
        addr_cap_n   = 1'b0;
        data_cap_n   = 1'b0;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
        split_req_n  = 1'b0;
`endif
      end
    endcase

    s_ready_n = (state_n == T_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= T_IDLE;
      req_q              <= '0;
      req_valid_q        <= 1'b0;
      resp_ready_q       <= 1'b0;
      rdata_q            <= '0;
      s_data_out_q       <= '0;
      s_data_out_valid_q <= 1'b0;
      s_ack_q            <= 1'b0;
      s_ready_q          <= 1'b1;
      addr_cap_q         <= 1'b0;
      data_cap_q         <= 1'b0;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
      cnt_q              <= '0;
      split_ack_q        <= 1'b0;
      split_req_q        <= 1'b0;
`endif
    end else begin
      state_q            <= state_n;
      req_q              <= req_n;
      req_valid_q        <= req_valid_n;
      resp_ready_q       <= resp_ready_n;
      rdata_q            <= rdata_n;
      s_data_out_q       <= s_data_out_n;
      s_data_out_valid_q <= s_data_out_valid_n;
      s_ack_q            <= s_ack_n;
      s_ready_q          <= s_ready_n;
      addr_cap_q         <= addr_cap_n;
      data_cap_q         <= data_cap_n;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
      cnt_q              <= cnt_n;
      split_ack_q        <= split_ack_n;
      split_req_q        <= split_req_n;
`endif
    end
  end

  assign req_valid        = req_valid_q;
  assign req_payload      = req_q;
  assign resp_ready       = resp_ready_q;
  assign s_ready          = s_ready_q;
  assign s_data_out       = s_data_out_q;
  assign s_data_out_valid = s_data_out_valid_q;
  assign s_ack            = s_ack_q;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
  assign s_split_ack      = split_ack_q;
  assign s_split_req      = split_req_q;
`else
  assign s_split_ack      = 1'b0;
  assign s_split_req      = 1'b0;
`endif

endmodule

// File: tb/tb_bus_bridge_target_if.sv
// Randomized self-checking bench for bus_bridge_target_if; expected cycle-level
// behaviour is derived per transaction from the bridge's protocol rules.
module tb_bus_bridge_target_if;
  import bus_bridge_pkg::*;

  localparam int unsigned SPLIT_TIMEOUT = 8;
`ifdef BUS_BRIDGE_TARGET_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  bus_bridge_req_t  req_payload;
  logic             resp_valid;
  logic             resp_ready;
  bus_bridge_resp_t resp_payload;
  logic             s_select;
  logic [15:0]      s_address_in;
  logic             s_address_in_valid;
  logic [7:0]       s_data_in;
  logic             s_data_in_valid;
  logic             s_rw;
  logic             s_ready;
  logic [7:0]       s_data_out;
  logic             s_data_out_valid;
  logic             s_ack;
  logic             s_split_ack;
  logic             s_split_req;
  logic             s_split_grant;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_rdata;

  bus_bridge_target_if #(.SPLIT_TIMEOUT(SPLIT_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_payload(resp_payload),
    .s_select(s_select), .s_address_in(s_address_in), .s_address_in_valid(s_address_in_valid),
    .s_data_in(s_data_in), .s_data_in_valid(s_data_in_valid), .s_rw(s_rw),
    .s_ready(s_ready), .s_data_out(s_data_out), .s_data_out_valid(s_data_out_valid),
    .s_ack(s_ack), .s_split_ack(s_split_ack), .s_split_req(s_split_req),
    .s_split_grant(s_split_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    s_address_in_valid = 1'b0;
    s_data_in_valid    = 1'b0;
    s_select           = 1'(($urandom % 2));
    s_address_in       = 16'($urandom);
    s_data_in          = 8'($urandom);
  endtask

  task automatic check_payload(input string tag, input logic wr,
                               input logic [15:0] addr, input logic [7:0] wdata);
    check({tag, "_addr"}, 32'(req_payload.addr), 32'(addr));
    check({tag, "_dir"}, 32'(req_payload.is_write), 32'(wr));
    if (wr) check({tag, "_wdata"}, 32'(req_payload.write_data), 32'(wdata));
  endtask

  // One complete bus transaction; order: 0 addr+data together, 1 addr first, 2 data first.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                         input int order, input int gap, input int stall, input int delay,
                         input int grant_dly, input logic [7:0] rdata, input logic resp_wr,
                         input bit noise);
    bit split;
    split = SPLIT_EN && (delay >= int'(SPLIT_TIMEOUT));

    if (noise) begin
      // Unselected traffic must not be captured
      s_select = 1'b0; s_address_in = ~addr; s_rw = ~wr; s_address_in_valid = 1'b1;
      s_data_in = ~wdata; s_data_in_valid = 1'b1;
      tick();
      bus_idle();
      tick();
      check("noise_no_req", 32'(req_valid), 32'd0);
    end

    s_select = 1'b1;
    case (order)
      0: begin
        s_address_in = addr; s_rw = wr; s_address_in_valid = 1'b1;
        s_data_in = wdata; s_data_in_valid = wr | noise;
        tick();
      end
      1: begin
        s_address_in = addr; s_rw = wr; s_address_in_valid = 1'b1;
        tick();
        bus_idle();
        for (int i = 0; i < gap; i++) begin
          tick();
          check("wait_data_no_req", 32'(req_valid), 32'd0);
        end
        s_select = 1'b1; s_data_in = wdata; s_data_in_valid = 1'b1;
        tick();
      end
      default: begin
        s_data_in = wdata; s_data_in_valid = 1'b1;
        tick();
        bus_idle();
        for (int i = 0; i < gap; i++) begin
          tick();
          check("wait_addr_no_req", 32'(req_valid), 32'd0);
        end
        s_select = 1'b1; s_address_in = addr; s_rw = wr; s_address_in_valid = 1'b1;
        tick();
      end
    endcase
    bus_idle();
    check("capture_ready", 32'(s_ready), 32'd1);
    check("capture_no_req", 32'(req_valid), 32'd0);

    tick();
    check("req_valid", 32'(req_valid), 32'd1);
    check("req_busy", 32'(s_ready), 32'd0);
    check_payload("req", wr, addr, wdata);

    // Stall the core; bus traffic outside idle is ignored
    for (int i = 0; i < stall; i++) begin
      req_ready = 1'b0;
      s_select = 1'b1; s_address_in = ~addr; s_address_in_valid = 1'b1;
      s_data_in = ~wdata; s_data_in_valid = 1'b1; s_rw = ~wr;
      tick();
      check("stall_req_valid", 32'(req_valid), 32'd1);
      check_payload("stall", wr, addr, wdata);
    end
    bus_idle();
    req_ready = 1'b1;
    tick();
    req_ready = 1'($urandom % 2);
    check("accept_req_drop", 32'(req_valid), 32'd0);
    check("accept_resp_ready", 32'(resp_ready), 32'd1);

    for (int i = 0; i < delay; i++) begin
      resp_valid = 1'b0;
      resp_payload = bus_bridge_resp_t'(9'($urandom));
      tick();
      check("wait_no_ack", 32'(s_ack), 32'd0);
      check("wait_resp_ready", 32'(resp_ready), 32'd1);
      check("wait_split_ack", 32'(s_split_ack), 32'(SPLIT_EN && (i == int'(SPLIT_TIMEOUT) - 1)));
      check("wait_req_valid", 32'(req_valid), 32'd0);
    end
    resp_valid = 1'b1;
    resp_payload = '{is_write: resp_wr, read_data: rdata};
    tick();
    resp_valid = 1'b0;
    resp_payload = bus_bridge_resp_t'(9'($urandom));
    check("resp_taken", 32'(resp_ready), 32'd0);
    check("resp_no_split_ack", 32'(s_split_ack), 32'd0);

    if (split) begin
      check("split_req_set", 32'(s_split_req), 32'd1);
      for (int i = 0; i < grant_dly; i++) begin
        tick();
        check("split_req_hold", 32'(s_split_req), 32'd1);
        check("split_no_ack", 32'(s_ack), 32'd0);
      end
      s_split_grant = 1'b1;
      tick();
      s_split_grant = 1'b0;
      check("split_req_drop", 32'(s_split_req), 32'd0);
      check("grant_no_ack", 32'(s_ack), 32'd0);
    end else begin
      check("no_split_req", 32'(s_split_req), 32'd0);
    end

    tick();
    if (!wr) last_rdata = rdata;
    check("ack", 32'(s_ack), 32'd1);
    check("ack_dvalid", 32'(s_data_out_valid), 32'(!wr));
    check("ack_data", 32'(s_data_out), 32'(last_rdata));
    check("ack_busy", 32'(s_ready), 32'd0);

    tick();
    check("post_ack", 32'(s_ack), 32'd0);
    check("post_dvalid", 32'(s_data_out_valid), 32'd0);
    check("post_ready", 32'(s_ready), 32'd1);
    check("post_data", 32'(s_data_out), 32'(last_rdata));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
    check({tag, "_resp_ready"}, 32'(resp_ready), 32'd0);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_dout"}, 32'(s_data_out), 32'd0);
    check({tag, "_dvalid"}, 32'(s_data_out_valid), 32'd0);
    check({tag, "_ack"}, 32'(s_ack), 32'd0);
    check({tag, "_split_ack"}, 32'(s_split_ack), 32'd0);
    check({tag, "_split_req"}, 32'(s_split_req), 32'd0);
    check({tag, "_payload"}, 32'(req_payload), 32'd0);
  endtask

  initial begin
    logic wr;
    int   order;
    rst_n = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_payload = '0;
    s_select = 1'b0; s_address_in = '0; s_address_in_valid = 1'b0;
    s_data_in = '0; s_data_in_valid = 1'b0; s_rw = 1'b0; s_split_grant = 1'b0;
    last_rdata = 8'h00;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(s_ready), 32'd1);

    // Directed cases
    run_txn(1'b1, 16'h1234, 8'hA5, 0, 0, 0, 2, 0, 8'h00, 1'b1, 1'b0);
    run_txn(1'b0, 16'h00F0, 8'h00, 0, 0, 0, 0, 0, 8'h3C, 1'b0, 1'b0);
    run_txn(1'b1, 16'hBEEF, 8'h5A, 2, 1, 5, 1, 0, 8'h99, 1'b1, 1'b0);
    run_txn(1'b0, 16'h0444, 8'h00, 0, 0, 0, 10, 3, 8'h77, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0555, 8'h00, 0, 0, 0, 7, 0, 8'h81, 1'b0, 1'b0);
    run_txn(1'b1, 16'h0666, 8'h12, 1, 2, 0, 0, 0, 8'hEE, 1'b0, 1'b1);
    run_txn(1'b0, 16'h0777, 8'h00, 0, 0, 1, 0, 0, 8'h42, 1'b1, 1'b1);

    // Reset while waiting for the response
    s_select = 1'b1; s_address_in = 16'hCAFE; s_rw = 1'b0; s_address_in_valid = 1'b1;
    tick();
    bus_idle();
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    tick();
    check("pre_reset_resp_ready", 32'(resp_ready), 32'd1);
    rst_n = 1'b0;
    #2;
    last_rdata = 8'h00;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check("after_reset_no_req", 32'(req_valid), 32'd0);
    run_txn(1'b0, 16'h0F0F, 8'h00, 0, 0, 0, 0, 0, 8'hC3, 1'b0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom % 2);
      order = wr ? int'($urandom % 3) : ((($urandom % 2) == 0) ? 0 : 2);
      run_txn(wr, 16'($urandom), 8'($urandom), order, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 4)), 8'($urandom), 1'($urandom % 2),
              1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
